fifo_umbrales: RTL and testbench
================================

Name: fifo_umbrales

Overview:
- Synchronous FIFO instantiated eight times, once per traffic class.
- Sits directly upstream of the flow-control state machine; each instance's fifo_empty drives one bit of that machine's empty_fifos bus.
- Consumes the threshold values the state machine latches in INIT (bajo_out/alto_out) and raises almost-empty/almost-full flags against them for back-pressure.
- Registered read data with a valid strobe; sticky error on overflow/underflow.

Parameters:
DATA_WIDTH, 6, width of each stored word
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH = 8 words
UMBRAL_WIDTH, 3, width of threshold inputs

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
wr_enable  input  1  push request
data_in  input  DATA_WIDTH  push data
rd_enable  input  1  pop request
umbral_bajo  input  UMBRAL_WIDTH  almost-empty threshold (from state machine bajo_out)
umbral_alto  input  UMBRAL_WIDTH  almost-full threshold (from state machine alto_out)
data_out  output  DATA_WIDTH  registered pop data
valid_out  output  1  data_out valid this cycle
fifo_empty  output  1  count == 0
fifo_full  output  1  count == DEPTH
almost_empty  output  1  count <= umbral_bajo
almost_full  output  1  umbral_alto != 0 and count >= umbral_alto
fifo_error  output  1  sticky overflow/underflow flag

Behaviour:
- State: wr_ptr, rd_ptr (ADDR_WIDTH, wrap naturally DEPTH-1 -> 0), count (ADDR_WIDTH+1 bits, 0..DEPTH), data_out, valid_out, fifo_error.
- Reset (reset==0, asynchronous, regardless of clk): pointers=0, count=0, data_out=0, valid_out=0, fifo_error=0.
  - Resulting flags: fifo_empty=1, fifo_full=0, almost_empty=1.
  - almost_full follows its formula; it is 0 for any umbral_alto != 0.
- Mid-operation reset: contents are abandoned, not cleared. Stale memory is never visible because valid_out=0.
- Push accepted: wr_enable and (not full, or a read is accepted the same cycle). Write mem[wr_ptr], wr_ptr+1.
- Pop accepted: rd_enable and not empty. data_out <= mem[rd_ptr] at the next edge, valid_out=1 for exactly that cycle, rd_ptr+1.
  - Read latency is 1 cycle.
  - With no accepted pop, valid_out=0 and data_out holds its last value.
- count: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- Simultaneous push+pop when full: both accepted, count stays DEPTH, no error.
- Simultaneous push+pop when empty: push accepted, pop is underflow (no bypass). Next cycle count=1, valid_out=0, fifo_error=1.
- Overflow: wr_enable when full and no accepted pop. Data dropped, pointers/count unchanged, fifo_error set.
- Underflow: rd_enable when empty. No pointer change, valid_out=0, fifo_error set.
- fifo_error is sticky until reset.
- fifo_empty, fifo_full, almost_empty, almost_full are combinational from count and the current threshold inputs.
  - Threshold changes take effect the same cycle.
  - umbral_alto=0 disables almost_full.
- Compare count against zero-extended thresholds (ADDR_WIDTH+1 bits). No sign issues.

Decomposition:
- Shared package: DATA_WIDTH, ADDR_WIDTH, UMBRAL_WIDTH defaults and DEPTH. These are common with the state machine and the top-level mux/demux.
- One natural sub-module: memoria_dp, a DEPTH x DATA_WIDTH dual-port RAM.
  - Synchronous write port (wr_en, wr_addr, wr_data).
  - Synchronous read port (rd_en, rd_addr, rd_data) supplies the 1-cycle read register.
  - No reset on the storage array.
- Pointer/count/flag logic stays in fifo_umbrales.

Test Plan:
- Reset then idle, umbral_bajo=1, umbral_alto=6 -> empty=1, almost_empty=1, full=0, almost_full=0, valid_out=0, error=0.
- Push 0x01..0x08 on consecutive cycles -> almost_empty drops after 2nd push; almost_full rises when count=6; full=1 after 8th. Then pop 8 -> data_out 0x01..0x08 in order, each one cycle after its rd_enable, valid_out high 8 cycles.
- Full FIFO, push 0x3F without pop -> count stays 8, contents unchanged, fifo_error=1 and stays 1. Then simultaneous push 0x15 + pop -> data_out=oldest word, count=8, 0x15 read last.
- Empty FIFO, rd_enable=1 with wr_enable=1 data 0x2A -> next cycle valid_out=0, count=1, fifo_error=1; following pop returns 0x2A.
- Wrap: push 5, pop 5, push 6, pop 6 -> data order preserved across pointer wrap 7->0, no error.
- Assert reset mid-stream with count=4 -> flags return to reset values immediately (asynchronous); after release, a single push/pop of 0x11 returns 0x11.

Source files
------------

// File: rtl/fifo_umbrales_pkg.sv
// rtl/fifo_umbrales_pkg.sv - shared widths and depth for the per-class FIFOs and flow-control logic
package fifo_umbrales_pkg;

    localparam int DATA_WIDTH   = 6;
    localparam int ADDR_WIDTH   = 3;
    localparam int UMBRAL_WIDTH = 3;
    localparam int DEPTH        = 2 ** ADDR_WIDTH;

    // {push accepted, pop accepted}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_t;

endpackage

// File: rtl/fifo_umbrales_if.sv
// rtl/fifo_umbrales_if.sv - push/pop, threshold and status signals of one FIFO instance
interface fifo_umbrales_if;
    import fifo_umbrales_pkg::*;

    logic                    wr_enable;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    rd_enable;
    logic [UMBRAL_WIDTH-1:0] umbral_bajo;
    logic [UMBRAL_WIDTH-1:0] umbral_alto;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    valid_out;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    almost_empty;
    logic                    almost_full;
    logic                    fifo_error;

    modport master (
        output wr_enable, data_in, rd_enable, umbral_bajo, umbral_alto,
        input  data_out, valid_out, fifo_empty, fifo_full,
               almost_empty, almost_full, fifo_error
    );

    modport slave (
        input  wr_enable, data_in, rd_enable, umbral_bajo, umbral_alto,
        output data_out, valid_out, fifo_empty, fifo_full,
               almost_empty, almost_full, fifo_error
    );

endinterface

// File: rtl/fifo_umbrales_memoria_dp.sv
// rtl/fifo_umbrales_memoria_dp.sv - DEPTH x DATA_WIDTH dual-port RAM with registered read port
module memoria_dp #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-address write and read in one cycle returns the old word (read-before-write).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_umbrales.sv
// rtl/fifo_umbrales.sv - per-class synchronous FIFO with almost-empty/almost-full thresholds
module fifo_umbrales
    import fifo_umbrales_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbrales_if.slave bus
);

    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          valid_q;
    logic          error_q;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    op_t           op;

    assign empty = (count == '0);
    assign full  = (count == CW'(2 ** AW));

    // No bypass: a pop on an empty FIFO fails even if a push arrives together.
    assign pop  = bus.rd_enable && !empty;
    assign push = bus.wr_enable && (!full || pop);
    assign op   = op_t'({push, pop});

    assign bus.fifo_empty   = empty;
    assign bus.fifo_full    = full;
    assign bus.almost_empty = (count <= CW'(bus.umbral_bajo));
    assign bus.almost_full  = (bus.umbral_alto != '0) && (count >= CW'(bus.umbral_alto));
    assign bus.valid_out    = valid_q;
    assign bus.fifo_error   = error_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            valid_q <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if ((bus.wr_enable && !push) || (bus.rd_enable && !pop)) begin
                error_q <= 1'b1;
            end
            case (op)
                OP_PUSH: count <= count + 1'b1;
                OP_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    memoria_dp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (bus.data_out)
    );

endmodule

// File: tb/tb_fifo_umbrales.sv
// tb/tb_fifo_umbrales.sv - directed bench with queue reference model for fifo_umbrales
module tb_fifo_umbrales;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    fifo_umbrales_if bus ();

    fifo_umbrales dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [5:0] q [$];
    logic [5:0] m_data;
    logic       m_valid;
    logic       m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            bit pop_ok;
            bit push_ok;
            pop_ok  = bus.rd_enable && (q.size() > 0);
            push_ok = bus.wr_enable && ((q.size() < 8) || pop_ok);
            m_valid = pop_ok;
            if (pop_ok) m_data = q.pop_front();
            if (push_ok) q.push_back(bus.data_in);
            if ((bus.wr_enable && !push_ok) || (bus.rd_enable && !pop_ok)) m_err = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("empty",    32'(bus.fifo_empty),   32'(q.size() == 0));
        chk("full",     32'(bus.fifo_full),    32'(q.size() == 8));
        chk("alm_emp",  32'(bus.almost_empty), 32'(q.size() <= int'(bus.umbral_bajo)));
        chk("alm_full", 32'(bus.almost_full),
            32'((bus.umbral_alto != 0) && (q.size() >= int'(bus.umbral_alto))));
        chk("valid",    32'(bus.valid_out),    32'(m_valid));
        chk("data",     32'(bus.data_out),     32'(m_data));
        chk("error",    32'(bus.fifo_error),   32'(m_err));
    end

    task automatic cyc(input logic w, input logic [5:0] d, input logic r);
        bus.wr_enable = w;
        bus.data_in   = d;
        bus.rd_enable = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.wr_enable = 1'b0;
        bus.rd_enable = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        bus.wr_enable   = 1'b0;
        bus.rd_enable   = 1'b0;
        bus.data_in     = '0;
        bus.umbral_bajo = 3'd1;
        bus.umbral_alto = 3'd6;
        do_reset();
        cyc(0, 0, 0);
        chk("rst_empty", 32'(bus.fifo_empty), 1);
        chk("rst_ae",    32'(bus.almost_empty), 1);
        chk("rst_full",  32'(bus.fifo_full), 0);
        chk("rst_af",    32'(bus.almost_full), 0);
        chk("rst_valid", 32'(bus.valid_out), 0);
        chk("rst_err",   32'(bus.fifo_error), 0);

        for (int k = 1; k <= 8; k++) begin
            cyc(1, 6'(k), 0);
            chk("fill_ae",   32'(bus.almost_empty), 32'(k <= 1));
            chk("fill_af",   32'(bus.almost_full),  32'(k >= 6));
            chk("fill_full", 32'(bus.fifo_full),    32'(k == 8));
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 1);
            chk("drain_valid", 32'(bus.valid_out), 1);
            chk("drain_data",  32'(bus.data_out),  32'(k));
        end
        cyc(0, 0, 0);
        chk("drain_idle_valid", 32'(bus.valid_out), 0);
        chk("drain_hold_data",  32'(bus.data_out),  8);

        for (int k = 0; k < 8; k++) cyc(1, 6'(8'h10 + k), 0);
        cyc(1, 6'h3F, 0);
        chk("ovf_err",  32'(bus.fifo_error), 1);
        chk("ovf_full", 32'(bus.fifo_full),  1);
        cyc(1, 6'h15, 1);
        chk("both_full_data",  32'(bus.data_out),  32'h10);
        chk("both_full_count", 32'(bus.fifo_full), 1);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 1);
            chk("post_ovf_data", 32'(bus.data_out), (k == 7) ? 32'h15 : 32'(8'h11 + k));
        end
        cyc(0, 0, 0);
        chk("err_sticky", 32'(bus.fifo_error), 1);

        do_reset();
        cyc(1, 6'h2A, 1);
        chk("unf_valid", 32'(bus.valid_out),  0);
        chk("unf_err",   32'(bus.fifo_error), 1);
        chk("unf_empty", 32'(bus.fifo_empty), 0);
        cyc(0, 0, 1);
        chk("unf_pop_data", 32'(bus.data_out), 32'h2A);

        do_reset();
        for (int k = 0; k < 5; k++) cyc(1, 6'(8'h20 + k), 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1);
            chk("wrap5_data", 32'(bus.data_out), 32'(8'h20 + k));
        end
        for (int k = 0; k < 6; k++) cyc(1, 6'(8'h30 + k), 0);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1);
            chk("wrap6_data", 32'(bus.data_out), 32'(8'h30 + k));
        end
        cyc(0, 0, 0);
        chk("wrap_err", 32'(bus.fifo_error), 0);

        bus.umbral_alto = 3'd0;
        for (int k = 0; k < 8; k++) cyc(1, 6'(k), 0);
        chk("af_disabled", 32'(bus.almost_full), 0);
        bus.umbral_alto = 3'd7;
        #1;
        chk("af_live_thresh", 32'(bus.almost_full), 1);
        bus.umbral_alto = 3'd6;
        for (int k = 0; k < 4; k++) cyc(0, 0, 1);
        cyc(0, 0, 0);

        rst_n = 1'b0;
        #1;
        chk("async_empty", 32'(bus.fifo_empty),   1);
        chk("async_full",  32'(bus.fifo_full),    0);
        chk("async_ae",    32'(bus.almost_empty), 1);
        chk("async_valid", 32'(bus.valid_out),    0);
        chk("async_data",  32'(bus.data_out),     0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 6'h11, 0);
        cyc(0, 0, 1);
        chk("post_rst_data",  32'(bus.data_out),  32'h11);
        chk("post_rst_valid", 32'(bus.valid_out), 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
